// File: rtl/rs_age_unit_pkg.sv
// Shared definitions for the ALU reservation station: opcodes, default widths,
// CDB slice helpers and the small bit-scan functions used by the select path.
package rs_age_unit_pkg;
    localparam int OP_W      = 6;
    localparam int XLEN_DEF  = 32;
    localparam int ROB_W_DEF = 4;
    localparam int MAX_DEPTH = 32;

    localparam logic        TRUE   = 1'b1;
    localparam logic        FALSE  = 1'b0;
    localparam logic [15:0] NULL16 = 16'h0000;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 6'd0,
        OP_SUB  = 6'd1,
        OP_AND  = 6'd2,
        OP_OR   = 6'd3,
        OP_XOR  = 6'd4,
        OP_SLL  = 6'd5,
        OP_SRL  = 6'd6,
        OP_SRA  = 6'd7,
        OP_SLT  = 6'd8,
        OP_SLTU = 6'd9
    } alu_op_e;

    // Bus k occupies slice k of the flattened cdb_tag / cdb_val ports.
    function automatic int cdb_tag_lo(input int k, input int rob_w);
        return k * rob_w;
    endfunction

    function automatic int cdb_val_lo(input int k, input int xlen);
        return k * xlen;
    endfunction

    function automatic logic [MAX_DEPTH-1:0] lowest_set(input logic [MAX_DEPTH-1:0] v);
        return v & (~v + {{(MAX_DEPTH-1){1'b0}}, 1'b1});
    endfunction

    function automatic int onehot_to_idx(input logic [MAX_DEPTH-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_DEPTH; i++)
            if (oh[i]) idx = idx | i;
        return idx;
    endfunction
endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is older than.
module rs_age_select
    import rs_age_unit_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [DEPTH-1:0]            grant,
    output logic [IDX_W-1:0]            grant_idx
);
    for (genvar i = 0; i < DEPTH; i++) begin : g_col
        logic [DEPTH-1:0] older_than_i;
        for (genvar j = 0; j < DEPTH; j++) begin : g_row
            assign older_than_i[j] = older[j][i];
        end
        assign grant[i] = ready[i] & ~|(ready & older_than_i);
    end

    assign grant_idx = IDX_W'(onehot_to_idx(MAX_DEPTH'(grant)));
endmodule

// File: rtl/rs_age_unit.sv
// Integer ALU reservation station: tag-based operand capture from the CDB buses,
// age-matrix oldest-ready issue, single-cycle flush on misprediction.
module rs_age_unit #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4,
    parameter int XLEN  = rs_age_unit_pkg::XLEN_DEF,
    parameter int ROB_W = rs_age_unit_pkg::ROB_W_DEF,
    parameter int OP_W  = rs_age_unit_pkg::OP_W,
    parameter int NCDB  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 jp_wrong,
    input  logic                 in_valid,
    input  logic [OP_W-1:0]      in_op,
    input  logic [ROB_W-1:0]     in_rob_idx,
    input  logic                 in_rs1_ready,
    input  logic                 in_rs2_ready,
    input  logic [XLEN-1:0]      in_reg1,
    input  logic [XLEN-1:0]      in_reg2,
    input  logic [XLEN-1:0]      in_imm,
    input  logic                 in_use_imm,
    output logic                 full,
    output logic [IDX_W:0]       count,
    input  logic [NCDB-1:0]      cdb_valid,
    input  logic [NCDB*ROB_W-1:0] cdb_tag,
    input  logic [NCDB*XLEN-1:0] cdb_val,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [OP_W-1:0]      iss_op,
    output logic [XLEN-1:0]      iss_val1,
    output logic [XLEN-1:0]      iss_val2,
    output logic [ROB_W-1:0]     iss_rob_idx
);
    import rs_age_unit_pkg::*;

    // A not-ready operand keeps its ROB tag in the low ROB_W bits of its value slot.
    logic [DEPTH-1:0]                valid, rdy1, rdy2;
    logic [DEPTH-1:0][OP_W-1:0]      op;
    logic [DEPTH-1:0][ROB_W-1:0]     rob;
    logic [DEPTH-1:0][XLEN-1:0]      val1, val2;
    logic [DEPTH-1:0][DEPTH-1:0]     older;
    logic [IDX_W:0]                  cnt;

    logic [NCDB-1:0][ROB_W-1:0]      bus_tag;
    logic [NCDB-1:0][XLEN-1:0]       bus_val;

    for (genvar k = 0; k < NCDB; k++) begin : g_bus
        assign bus_tag[k] = cdb_tag[cdb_tag_lo(k, ROB_W) +: ROB_W];
        assign bus_val[k] = cdb_val[cdb_val_lo(k, XLEN) +: XLEN];
    end

    logic [DEPTH-1:0]            hit1, hit2;
    logic [DEPTH-1:0][XLEN-1:0]  wval1, wval2;
    logic                        byp1, byp2;
    logic [XLEN-1:0]             bval1, bval2;

    // Walk buses high to low so the lowest matching bus is the one that sticks.
    always_comb begin
        hit1  = '0;
        hit2  = '0;
        wval1 = '0;
        wval2 = '0;
        byp1  = FALSE;
        byp2  = FALSE;
        bval1 = '0;
        bval2 = '0;
        for (int k = NCDB - 1; k >= 0; k--) begin
            if (cdb_valid[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (bus_tag[k] == val1[i][ROB_W-1:0]) begin
                        hit1[i]  = TRUE;
                        wval1[i] = bus_val[k];
                    end
                    if (bus_tag[k] == val2[i][ROB_W-1:0]) begin
                        hit2[i]  = TRUE;
                        wval2[i] = bus_val[k];
                    end
                end
                if (bus_tag[k] == in_reg1[ROB_W-1:0]) begin
                    byp1  = TRUE;
                    bval1 = bus_val[k];
                end
                if (bus_tag[k] == in_reg2[ROB_W-1:0]) begin
                    byp2  = TRUE;
                    bval2 = bus_val[k];
                end
            end
        end
    end

    logic [DEPTH-1:0] ready, grant, free_oh;
    logic [IDX_W-1:0] sel, free_idx;
    logic             accept, fire;

    assign ready = valid & rdy1 & rdy2;

    rs_age_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
        .ready     (ready),
        .older     (older),
        .grant     (grant),
        .grant_idx (sel)
    );

    assign free_oh  = DEPTH'(lowest_set(MAX_DEPTH'(~valid)));
    assign free_idx = IDX_W'(onehot_to_idx(MAX_DEPTH'(free_oh)));

    assign count       = cnt;
    assign full        = (cnt == (IDX_W+1)'(DEPTH));
    assign iss_valid   = |ready;
    assign iss_op      = op[sel];
    assign iss_val1    = val1[sel];
    assign iss_val2    = val2[sel];
    assign iss_rob_idx = rob[sel];

    assign accept = in_valid & ~full;
    assign fire   = iss_valid & iss_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            older <= '0;
            cnt   <= '0;
        end else if (rdy) begin
            if (jp_wrong) begin
                valid <= '0;
                cnt   <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid[i] && !rdy1[i] && hit1[i]) begin
                        rdy1[i] <= TRUE;
                        val1[i] <= wval1[i];
                    end
                    if (valid[i] && !rdy2[i] && hit2[i]) begin
                        rdy2[i] <= TRUE;
                        val2[i] <= wval2[i];
                    end
                end
                if (fire) valid <= valid & ~grant;
                // The free slot is never the granted one, so this bit write cannot collide.
                if (accept) begin
                    valid[free_idx] <= TRUE;
                    op[free_idx]    <= in_op;
                    rob[free_idx]   <= in_rob_idx;
                    rdy1[free_idx]  <= in_rs1_ready | byp1;
                    val1[free_idx]  <= (!in_rs1_ready && byp1) ? bval1 : in_reg1;
                    rdy2[free_idx]  <= in_use_imm | in_rs2_ready | byp2;
                    val2[free_idx]  <= in_use_imm ? in_imm :
                                       (!in_rs2_ready && byp2) ? bval2 : in_reg2;
                    older[free_idx] <= '0;
                    for (int j = 0; j < DEPTH; j++)
                        older[j][free_idx] <= valid[j];
                end
                cnt <= cnt + (IDX_W+1)'(accept) - (IDX_W+1)'(fire);
            end
        end
    end
endmodule
